matrix_ram_reader: RTL
======================

// Module: matrix_ram_reader
// PURPOSE
//  Downstream read sequencer for the byte-addressed matrix RAM (64-bit words, 3-bit byte
//  select, 1-cycle registered read). On start, walks a run of consecutive bytes (word-major,
//  byte 0..7 within a word) and delivers them as a valid/ready byte stream to the multiply
//  datapath. Absorbs the RAM read latency with a small credit-managed FIFO (full throughput).
// PARAMETERS
//  DATA_WIDTH    8  byte width; equals the RAM data/out width
//  ADDRESS_BITS  2  RAM word-address width; capacity CAP = 2**ADDRESS_BITS*8 bytes
//  FIFO_DEPTH    4  output buffer entries; >=2, power of 2; 4 sustains 1 byte/cycle
//  (derived) IDX_W = ADDRESS_BITS+3 = linear byte-index width
// PORTS
//  clk          in   1             clock, rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  start        in   1             1-cycle request; sampled only while busy=0
//  start_idx    in   IDX_W         first linear byte index {word, byte}
//  length       in   IDX_W+1       bytes to read; 0 allowed; values >CAP clamp to CAP
//  ram_enable_n out  1             RAM chip enable, active low (low only on issue cycles)
//  ram_wren_n   out  1             RAM write enable, constant 1 (read-only master)
//  ram_address  out  ADDRESS_BITS  RAM word address
//  ram_byteena  out  3             RAM byte select
//  ram_out      in   DATA_WIDTH    RAM registered read data
//  m_valid      out  1             stream byte valid
//  m_ready      in   1             downstream accept
//  m_data       out  DATA_WIDTH    stream byte (signed, passed unchanged)
//  m_last       out  1             marks final byte of the run (qualified by m_valid)
//  busy         out  1             run in progress
//  done         out  1             1-cycle pulse at run completion
// BEHAVIOUR
//  - Reset (async): ram_enable_n=1, ram_wren_n=1, ram_address=0, ram_byteena=0, m_valid=0,
//    m_data=0, m_last=0, busy=0, done=0; FIFO, counters, in-flight flag cleared. Reset
//    mid-run aborts the run; no done pulse.
//  - States: IDLE -> RUN on start with busy=0 (latch start_idx, clamped length; busy=1 next
//    cycle). RUN -> IDLE when the last byte handshakes (m_valid&m_ready&m_last): next cycle
//    busy=0, done=1. length=0: RUN entered, zero reads, done=1 the cycle after entry.
//    start while busy=1 ignored.
//  - Issue: in RUN, issue one read per cycle when issued<length and fifo_count+inflight
//    < FIFO_DEPTH (registered values, no same-cycle pop credit). Issue cycle:
//    ram_enable_n=0, ram_address=idx[IDX_W-1:3], ram_byteena=idx[2:0]; idx <= idx+1
//    mod 2**IDX_W (wraps last byte of last word -> word 0 byte 0). Non-issue cycles:
//    ram_enable_n=1, address/byteena hold.
//  - Capture: inflight set the cycle after issue; ram_out written into FIFO at the end of
//    that cycle (RAM output is valid exactly one cycle after the issue cycle).
//  - Latency: start in cycle c0 -> first issue c1 -> first m_valid c3. With m_ready=1
//    throughout: one byte per cycle, no bubbles.
//  - Stream: m_valid=FIFO non-empty; m_data/m_last from FIFO head; both held stable while
//    m_valid=1 and m_ready=0. Pop on m_valid&m_ready. Push and pop in the same cycle legal
//    (count unchanged). FIFO never overflows (credit rule); m_ready ignored when empty.
//  - m_last stored per entry, set on the entry from the length-th read.
// TESTING
//  1 Preload word w byte b = {w,b} (8'h00..8'h1F); start_idx=0, length=32, m_ready=1
//    -> bytes 00..1F in order, m_valid first in c3, no gaps, m_last on 1F, done one
//    cycle after 1F's handshake.
//  2 start_idx=5'd30, length=4 -> bytes 1E,1F,00,01 (address wraps 3->0), m_last on 01.
//  3 length=32, m_ready toggled 1,0,0,1 repeating -> same 32 bytes in order, m_data stable
//    while stalled, ram_enable_n low no more than FIFO_DEPTH times ahead of pops.
//  4 length=0 -> no ram_enable_n low, m_valid never 1, done pulse two cycles after start.
//  5 length=40 -> clamped to 32 bytes; second start while busy ignored (no extra reads).
//  6 rst_n low mid-run (after 10 bytes) -> all outputs at reset values immediately, no
//    done; new start after release reads correctly from its start_idx.

Source files
------------

// File: rtl/matrix_ram_reader.sv
// rtl/matrix_ram_reader.sv - sequential byte-run reader for the matrix RAM with a credit-managed output FIFO
module matrix_ram_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_BITS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDRESS_BITS+2:0] start_idx,
    input  logic [ADDRESS_BITS+3:0] length,
    output logic                    ram_enable_n,
    output logic                    ram_wren_n,
    output logic [ADDRESS_BITS-1:0] ram_address,
    output logic [2:0]              ram_byteena,
    input  logic [DATA_WIDTH-1:0]   ram_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = ADDRESS_BITS + 3;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W:0]   CAP     = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0]   LEN_ONE = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEPTH_C = FIFO_DEPTH[CNT_W-1:0];

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W:0]          run_len;
    logic [IDX_W:0]          issued;
    logic                    inflight;
    logic                    inflight_last;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [2:0]              bsel_q;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   last_mem;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;

    logic                    fifo_empty;
    logic [CNT_W-1:0]        credit;
    logic [IDX_W:0]          issued_next;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    last_pop;

    // Credit uses registered occupancy only: a pop this cycle does not free a slot until next cycle.
    always_comb begin
        fifo_empty  = (fifo_count == '0);
        credit      = fifo_count + {{PTR_W{1'b0}}, inflight};
        issued_next = issued + LEN_ONE;
        issue       = (state == S_RUN) && (issued < run_len) && (credit < DEPTH_C);
        push        = inflight;
        pop         = !fifo_empty && m_ready;
        last_pop    = pop && last_mem[rd_ptr];
    end

    assign ram_wren_n   = 1'b1;
    assign ram_enable_n = !issue;
    assign ram_address  = issue ? idx[IDX_W-1:3] : addr_q;
    assign ram_byteena  = issue ? idx[2:0] : bsel_q;
    assign m_valid      = !fifo_empty;
    assign m_data       = fifo_empty ? '0 : mem[rd_ptr];
    assign m_last       = !fifo_empty && last_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            run_len       <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            addr_q        <= '0;
            bsel_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (issued_next == run_len);
            if (issue) begin
                idx    <= idx + IDX_ONE;
                issued <= issued_next;
                addr_q <= idx[IDX_W-1:3];
                bsel_q <= idx[2:0];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        idx     <= start_idx;
                        run_len <= (length > CAP) ? CAP : length;
                        issued  <= '0;
                    end
                end
                S_RUN: begin
                    // A zero-length run finishes on its first RUN cycle with no reads.
                    if ((run_len == '0) || last_pop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            last_mem   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr]      <= ram_out;
                last_mem[wr_ptr] <= inflight_last;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
